spot_frame_writer: RTL and testbench
====================================

# spot_frame_writer

- Sits directly upstream of the spot finder.
- Takes the camera pixel stream (one 8-bit pixel per clock max), packs 32 consecutive pixels into one 256-bit kernel word and writes it to the spot finder block RAM.
- Measures the frame geometry (`cam_kernels_x`, `cam_lines_y`) and pulses `frame_done` when a complete frame is in RAM.
- `frame_done` drives the spot finder's `reset` input, which restarts the analysis.

## Interface

Parameters:
- `MAX_WORDS`, 16384 — RAM depth in 256-bit words; word addresses `0 … MAX_WORDS-1`.

Ports:
- `clk_in` input 1 — single clock; all logic on its rising edge.
- `reset` input 1 — reset is synchronous and active-high.
- `pix_data` input 8 — pixel value.
- `pix_valid` input 1 — `pix_data` valid this cycle; always accepted, no backpressure.
- `frame_start` input 1 — one-cycle pulse; first pixel of the frame may coincide.
- `line_end` input 1 — one-cycle pulse; if `pix_valid` is high in the same cycle, that pixel is the last of the line.
- `frame_end` input 1 — one-cycle pulse; the last line's `line_end` must come in the same cycle or earlier.
- `mem_we` output 1 — RAM write enable.
- `mem_address` output 14 — RAM word address.
- `mem_data` output 256 — packed kernel word.
- `cam_kernels_x` output 16 — kernels per line of the last completed frame.
- `cam_lines_y` output 16 — lines of the last completed frame.
- `frame_done` output 1 — one-cycle pulse: frame fully written, geometry valid.
- `busy` output 1 — high in CAPTURE and FLUSH.
- `overflow` output 1 — sticky; a word was dropped because RAM was full.
- `line_err` output 1 — sticky; a line's kernel count differed from line 0's.
- `max_pixel` output 8 — brightest pixel of the last frame (see Configuration).

## Operation

States: IDLE, CAPTURE, FLUSH, DONE.

- **IDLE**
  - Pixels, `line_end` and `frame_end` are ignored.
  - `frame_start` → CAPTURE: clear `word_addr`, `pix_idx`, kernel/line counters, `overflow`, `line_err`.
  - If `pix_valid` coincides with `frame_start`, that pixel is accepted as pixel 0.
- **CAPTURE**
  - Each accepted pixel is stored at `shift_word[8*pix_idx +: 8]`; `pix_idx` is 5-bit. Pixel 0 = leftmost = bits `[7:0]`.
  - A write is triggered when:
    - the 32nd pixel is accepted (`pix_idx`=31), or
    - `line_end` arrives with a partial word (`pix_idx`≠0 after accepting any coincident pixel).
  - A full word and a coincident `line_end` produce exactly one write.
  - Unused bytes of a partial word are written as 0.
  - `line_end` with no pixels since the previous `line_end` is ignored: no write, no line count.
  - On a counted `line_end`:
    - `line_cnt`++.
    - If it was line 0, latch its kernel count as `ref_kernels`.
    - Otherwise compare against `ref_kernels`; a mismatch sets `line_err`.
  - `frame_end` → FLUSH.
  - `frame_start` in CAPTURE aborts the frame: restart as from IDLE, no `frame_done`, RAM contents undefined.
- **FLUSH** (1 cycle)
  - If a partial word is still pending (`frame_end` without a `line_end`), write it and count it as a line.
  - → DONE.
- **DONE** (1 cycle)
  - Latch `cam_kernels_x` ← `ref_kernels` and `cam_lines_y` ← `line_cnt`.
  - Pulse `frame_done`, then → IDLE.
- **Overflow**
  - A write with `word_addr` = `MAX_WORDS` is suppressed (`mem_we` stays 0) and sets `overflow`.
  - `word_addr` saturates and never wraps.
  - The frame still completes and `frame_done` still pulses.
- **Arithmetic**
  - Counters are 16-bit and saturate at 0xFFFF.
  - `word_addr` is 15-bit internally so that `MAX_WORDS` can be represented; `mem_address` is its low 14 bits.

## Timing

- Write latency is 1 cycle: the triggering edge registers `mem_we`=1, `mem_address`=`word_addr`, and `mem_data`. `word_addr` increments at the same edge.
- `mem_we` is high for exactly one cycle per word.
- Back-to-back full words (32 pixels per 32 cycles) are sustained with no gaps.
- `frame_end` coincident with the final `line_end`:
  - Last write on cycle T+1.
  - FLUSH on T+1, DONE on T+2.
  - `frame_done` high on T+3.
  - `cam_*` valid from T+3.
- `cam_kernels_x` and `cam_lines_y` hold until the next DONE.
- Reset values: every output is 0; state is IDLE.
- `reset` has priority over all inputs. Mid-frame reset abandons the frame and produces no `frame_done`.

## Configuration

- `SPOT_WRITER_MAXPIX_EN` defined:
  - `max_pixel` tracks the maximum accepted pixel of the frame (cleared at `frame_start`).
  - Latched to the output in DONE.
- `SPOT_WRITER_MAXPIX_EN` not defined: the tracking logic is absent and `max_pixel` is constant 0.

## Test plan

- **Full frame:** 64 pixels/line (values 0..63), 3 lines, `frame_end` with the last `line_end`.
  - 6 writes at addresses 0..5.
  - Word 0 bytes = 0..31.
  - `cam_kernels_x`=2, `cam_lines_y`=3, one `frame_done`.
- **Partial kernel:** 40-pixel lines.
  - Second word of each line has bytes 0..7 = pixels 32..39 and bytes 8..31 = 0.
  - `cam_kernels_x`=2.
- **Line mismatch:** line 0 = 64 px, line 1 = 96 px.
  - `line_err`=1, `cam_kernels_x`=2, `cam_lines_y`=2.
- **Overflow:** `MAX_WORDS`=4, 6 full words.
  - Exactly 4 writes (addresses 0..3); `overflow`=1; `frame_done` still pulses.
- **Abort:** `frame_start` after 10 words, then a 1-line 32-pixel frame.
  - No `frame_done` for the aborted frame.
  - New frame writes address 0; `cam_lines_y`=1.
- **Reset and max pixel:** `reset` asserted mid-line.
  - All outputs 0 next cycle, no write.
  - With `SPOT_WRITER_MAXPIX_EN`, a frame peaking at 200 gives `max_pixel`=200; without the macro it reads 0.

Source files
------------

// File: rtl/spot_frame_writer_if.sv
// ---------------------------------------------------------------------------
// spot_frame_writer_if
//
// Bundles the camera pixel stream and the spot finder RAM write port used by
// spot_frame_writer.
//
// Handshake semantics: the pixel stream has a valid and no ready. Every cycle
// with pix_valid=1 hands one pixel to the writer, and the writer always takes
// it. frame_start, line_end and frame_end are single-cycle strobes. mem_we is
// a single-cycle write strobe qualifying mem_address/mem_data, and the RAM
// must take every write because it cannot stall the writer.
//
// Signals:
//   pix_data    [7:0]   pixel value
//   pix_valid           pix_data valid this cycle
//   frame_start         first cycle of a frame (may carry pixel 0)
//   line_end            last cycle of a line (may carry the last pixel)
//   frame_end           end of frame (same cycle as or after last line_end)
//   mem_we              RAM write enable
//   mem_address [13:0]  RAM word address
//   mem_data    [255:0] packed kernel word, pixel 0 in bits [7:0]
//
// Modports:
//   slave  - the frame writer (consumes pixels, drives the RAM port)
//   master - the camera/RAM side (drives pixels, observes the RAM port)
// ---------------------------------------------------------------------------
interface spot_frame_writer_if;
    logic [7:0]   pix_data;
    logic         pix_valid;
    logic         frame_start;
    logic         line_end;
    logic         frame_end;
    logic         mem_we;
    logic [13:0]  mem_address;
    logic [255:0] mem_data;

    modport slave (
        input  pix_data, pix_valid, frame_start, line_end, frame_end,
        output mem_we, mem_address, mem_data
    );

    modport master (
        output pix_data, pix_valid, frame_start, line_end, frame_end,
        input  mem_we, mem_address, mem_data
    );
endinterface

// File: rtl/spot_frame_writer.sv
// ---------------------------------------------------------------------------
// spot_frame_writer
//
// Packs the camera pixel stream into 256-bit kernel words (32 pixels, pixel 0
// in the low byte) and writes them to the spot finder block RAM. It also
// measures the frame geometry and pulses frame_done when a complete frame
// is in RAM.
//
// Parameters:
//   MAX_WORDS      RAM depth in 256-bit words. Writes beyond the last word
//                  are dropped and flagged with overflow.
//
// Optional feature macro:
//   SPOT_WRITER_MAXPIX_EN  when defined, max_pixel reports the brightest
//                          pixel of the last completed frame. Otherwise
//                          max_pixel is constant 0.
//
// Ports:
//   clk_in         clock, all logic on the rising edge
//   reset          synchronous, active-high
//   bus            spot_frame_writer_if.slave (pixel stream in, RAM port out)
//   cam_kernels_x  kernels per line of the last completed frame
//   cam_lines_y    lines of the last completed frame
//   frame_done     one-cycle pulse, frame written and geometry valid
//   busy           high while capturing or flushing
//   overflow       sticky, a word was dropped because RAM was full
//   line_err       sticky, a line's kernel count differed from line 0's
//   max_pixel      brightest pixel of the last frame (see macro above)
//   fsm_state      current FSM state (0 idle, 1 capture, 2 flush, 3 done)
// ---------------------------------------------------------------------------
module spot_frame_writer #(
    parameter int MAX_WORDS = 16384
) (
    input  logic               clk_in,
    input  logic               reset,
    spot_frame_writer_if.slave bus,
    output logic [15:0]        cam_kernels_x,
    output logic [15:0]        cam_lines_y,
    output logic               frame_done,
    output logic               busy,
    output logic               overflow,
    output logic               line_err,
    output logic [7:0]         max_pixel,
    output logic [1:0]         fsm_state
);
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CAPTURE = 2'd1;
    localparam logic [1:0] ST_FLUSH   = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    // One wider than the RAM address so that "RAM full" is representable.
    localparam logic [14:0] MAX_ADDR = 15'(MAX_WORDS);

    logic [1:0]   state;
    logic [14:0]  word_addr;
    logic [4:0]   pix_idx;
    logic [255:0] shift_word;
    logic         line_pix_seen;
    logic [15:0]  kern_cnt;
    logic [15:0]  line_cnt;
    logic [15:0]  ref_kernels;

    logic         mem_we_q;
    logic [13:0]  mem_address_q;
    logic [255:0] mem_data_q;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic         capture_run;
    logic         active;
    logic         accept;
    logic         full_word;
    logic         line_close;
    logic         do_write;
    logic         do_line;
    logic [4:0]   idx_next;
    logic [255:0] word_next;
    logic [15:0]  line_kernels;

    always_comb begin
        // A frame_start during capture restarts the frame, so the normal
        // datapath is suppressed for that cycle.
        capture_run = (state == ST_CAPTURE) && !bus.frame_start;
        active      = capture_run || (state == ST_FLUSH);
        accept      = capture_run && bus.pix_valid;

        word_next = shift_word;
        if (accept) begin
            word_next[{pix_idx, 3'b000} +: 8] = bus.pix_data;
        end
        idx_next  = accept ? pix_idx + 5'd1 : pix_idx;
        full_word = accept && (pix_idx == 5'd31);

        // FLUSH behaves like an implicit line_end for a dangling line.
        line_close   = (capture_run && bus.line_end) || (state == ST_FLUSH);
        // idx_next wraps to 0 on a full word, so a coincident line_end does
        // not add a second write.
        do_write     = full_word || (line_close && (idx_next != 5'd0));
        do_line      = line_close && (line_pix_seen || accept);
        line_kernels = do_write ? sat_inc(kern_cnt) : kern_cnt;
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state         <= ST_IDLE;
            word_addr     <= '0;
            pix_idx       <= '0;
            shift_word    <= '0;
            line_pix_seen <= 1'b0;
            kern_cnt      <= '0;
            line_cnt      <= '0;
            ref_kernels   <= '0;
            mem_we_q      <= 1'b0;
            mem_address_q <= '0;
            mem_data_q    <= '0;
            cam_kernels_x <= '0;
            cam_lines_y   <= '0;
            frame_done    <= 1'b0;
            overflow      <= 1'b0;
            line_err      <= 1'b0;
        end else begin
            mem_we_q   <= 1'b0;
            frame_done <= 1'b0;

            if (active) begin
                shift_word <= word_next;
                pix_idx    <= idx_next;
                if (accept) begin
                    line_pix_seen <= 1'b1;
                end
                if (do_write) begin
                    // Clearing after each write keeps unused bytes of a
                    // partial word at zero.
                    shift_word <= '0;
                    pix_idx    <= '0;
                    kern_cnt   <= sat_inc(kern_cnt);
                    if (word_addr == MAX_ADDR) begin
                        overflow <= 1'b1;
                    end else begin
                        mem_we_q      <= 1'b1;
                        mem_address_q <= word_addr[13:0];
                        mem_data_q    <= word_next;
                        word_addr     <= word_addr + 15'd1;
                    end
                end
                if (line_close) begin
                    line_pix_seen <= 1'b0;
                end
                if (do_line) begin
                    kern_cnt <= '0;
                    line_cnt <= sat_inc(line_cnt);
                    if (line_cnt == 16'd0) begin
                        ref_kernels <= line_kernels;
                    end else if (line_kernels != ref_kernels) begin
                        line_err <= 1'b1;
                    end
                end
            end

            case (state)
                ST_IDLE, ST_CAPTURE: begin
                    if (bus.frame_start) begin
                        state         <= ST_CAPTURE;
                        word_addr     <= '0;
                        kern_cnt      <= '0;
                        line_cnt      <= '0;
                        ref_kernels   <= '0;
                        overflow      <= 1'b0;
                        line_err      <= 1'b0;
                        shift_word    <= '0;
                        pix_idx       <= bus.pix_valid ? 5'd1 : 5'd0;
                        line_pix_seen <= bus.pix_valid;
                        if (bus.pix_valid) begin
                            shift_word[7:0] <= bus.pix_data;
                        end
                    end else if ((state == ST_CAPTURE) && bus.frame_end) begin
                        state <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    state <= ST_DONE;
                end
                ST_DONE: begin
                    cam_kernels_x <= ref_kernels;
                    cam_lines_y   <= line_cnt;
                    frame_done    <= 1'b1;
                    state         <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef SPOT_WRITER_MAXPIX_EN
    logic [7:0] frame_max;

    always_ff @(posedge clk_in) begin
        if (reset) begin
            frame_max <= '0;
            max_pixel <= '0;
        end else begin
            if (((state == ST_IDLE) || (state == ST_CAPTURE)) && bus.frame_start) begin
                frame_max <= bus.pix_valid ? bus.pix_data : 8'd0;
            end else if (accept && (bus.pix_data > frame_max)) begin
                frame_max <= bus.pix_data;
            end
            if (state == ST_DONE) begin
                max_pixel <= frame_max;
            end
        end
    end
`else
    assign max_pixel = 8'd0;
`endif

    assign bus.mem_we      = mem_we_q;
    assign bus.mem_address = mem_address_q;
    assign bus.mem_data    = mem_data_q;
    assign busy            = (state == ST_CAPTURE) || (state == ST_FLUSH);
    assign fsm_state       = state;

endmodule

// File: tb/tb_spot_frame_writer.sv
// ---------------------------------------------------------------------------
// tb_spot_frame_writer
//
// Directed bench for spot_frame_writer. A default-depth instance covers
// packing, geometry, line errors, abort and reset. A second instance with
// MAX_WORDS=4 covers RAM overflow. Expected RAM words are built from the
// pixel sequence each driver call sends and are queued for the write monitor.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_spot_frame_writer;
    localparam int W = 270;

`ifdef SPOT_WRITER_MAXPIX_EN
    localparam bit MAXPIX = 1'b1;
`else
    localparam bit MAXPIX = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk_in = 1'b0;
    logic reset  = 1'b1;
    always #5 clk_in = ~clk_in;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- DUTs ----------------
    spot_frame_writer_if bif();
    spot_frame_writer_if oif();

    logic [15:0] b_kx, b_ly, o_kx, o_ly;
    logic        b_done, b_busy, b_ov, b_lerr, o_done, o_busy, o_ov, o_lerr;
    logic [7:0]  b_max, o_max;
    logic [1:0]  b_state, o_state;

    spot_frame_writer dut (
        .clk_in        (clk_in),
        .reset         (reset),
        .bus           (bif),
        .cam_kernels_x (b_kx),
        .cam_lines_y   (b_ly),
        .frame_done    (b_done),
        .busy          (b_busy),
        .overflow      (b_ov),
        .line_err      (b_lerr),
        .max_pixel     (b_max),
        .fsm_state     (b_state)
    );

    spot_frame_writer #(.MAX_WORDS(4)) dut_ov (
        .clk_in        (clk_in),
        .reset         (reset),
        .bus           (oif),
        .cam_kernels_x (o_kx),
        .cam_lines_y   (o_ly),
        .frame_done    (o_done),
        .busy          (o_busy),
        .overflow      (o_ov),
        .line_err      (o_lerr),
        .max_pixel     (o_max),
        .fsm_state     (o_state)
    );

    bit use_ov = 1'b0;

    wire [15:0] s_kx    = use_ov ? o_kx    : b_kx;
    wire [15:0] s_ly    = use_ov ? o_ly    : b_ly;
    wire        s_done  = use_ov ? o_done  : b_done;
    wire        s_busy  = use_ov ? o_busy  : b_busy;
    wire        s_ov    = use_ov ? o_ov    : b_ov;
    wire        s_lerr  = use_ov ? o_lerr  : b_lerr;
    wire [7:0]  s_max   = use_ov ? o_max   : b_max;
    wire [1:0]  s_state = use_ov ? o_state : b_state;

    // ---------------- scoreboard ----------------
    int vectors     = 0;
    int miscompares = 0;
    logic [W-1:0] exp_q[$];
    int exp_addr    = 0;
    int done_cnt    = 0;
    int ov_done_cnt = 0;
    int ov_wr_cnt   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_w(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk_in) begin
        if (bif.mem_we === 1'b1) begin
            vectors++;
            assert (exp_q.size() != 0) else begin
                miscompares++;
                $error("FAIL unexpected_write observed addr=%0h expected no write", bif.mem_address);
            end
            if (exp_q.size() != 0) begin
                check_w("write", {bif.mem_address, bif.mem_data}, exp_q.pop_front());
            end
        end
        if (oif.mem_we === 1'b1) begin
            check("ov_write_addr", 32'(oif.mem_address), 32'(ov_wr_cnt));
            ov_wr_cnt++;
        end
        if (b_done === 1'b1) done_cnt++;
        if (o_done === 1'b1) ov_done_cnt++;
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [7:0] d, input logic fs,
                          input logic le, input logic fe);
        bif.pix_valid = use_ov ? 1'b0 : v;
        bif.pix_data  = use_ov ? 8'd0 : d;
        bif.frame_start = use_ov ? 1'b0 : fs;
        bif.line_end  = use_ov ? 1'b0 : le;
        bif.frame_end = use_ov ? 1'b0 : fe;
        oif.pix_valid = use_ov ? v : 1'b0;
        oif.pix_data  = use_ov ? d : 8'd0;
        oif.frame_start = use_ov ? fs : 1'b0;
        oif.line_end  = use_ov ? le : 1'b0;
        oif.frame_end = use_ov ? fe : 1'b0;
    endtask

    // Sends one line of npix consecutive pixels (values base, base+1, ...).
    // fs marks pixel 0 as frame_start, le/fe put line_end/frame_end on the
    // last pixel. Expected RAM words are queued for the default instance.
    task automatic drive_line(input int npix, input int base, input bit fs,
                              input bit le, input bit fe);
        int nwords;
        logic [255:0] d;
        if (fs) exp_addr = 0;
        if (!use_ov) begin
            nwords = le ? (npix + 31) / 32 : npix / 32;
            for (int w = 0; w < nwords; w++) begin
                d = '0;
                for (int j = 0; j < 32; j++) begin
                    if (32 * w + j < npix) d[8*j +: 8] = 8'(base + 32 * w + j);
                end
                exp_q.push_back({14'(exp_addr), d});
                exp_addr++;
            end
        end
        for (int i = 0; i < npix; i++) begin
            set_in(1'b1, 8'(base + i), fs && (i == 0), le && (i == npix - 1), fe && (i == npix - 1));
            step();
        end
        set_in(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Call right after the cycle carrying the final line_end/frame_end.
    task automatic check_frame_end(input int kx, input int ly, input int lerr,
                                   input int ov, input int mx);
        check("state_flush", 32'(s_state), 32'd2);
        check("busy_flush", 32'(s_busy), 32'd1);
        step();
        check("state_done", 32'(s_state), 32'd3);
        check("done_not_early", 32'(s_done), 32'd0);
        step();
        check("frame_done", 32'(s_done), 32'd1);
        check("cam_kernels_x", 32'(s_kx), 32'(kx));
        check("cam_lines_y", 32'(s_ly), 32'(ly));
        check("line_err", 32'(s_lerr), 32'(lerr));
        check("overflow", 32'(s_ov), 32'(ov));
        check("max_pixel", 32'(s_max), MAXPIX ? 32'(mx) : 32'd0);
        check("state_idle", 32'(s_state), 32'd0);
        step();
        check("done_one_cycle", 32'(s_done), 32'd0);
        if (!use_ov) check("all_writes_seen", 32'(exp_q.size()), 32'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        set_in(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        step();
        step();
        check("rst_mem_we", 32'(bif.mem_we), 32'd0);
        check("rst_mem_address", 32'(bif.mem_address), 32'd0);
        check_w("rst_mem_data", W'(bif.mem_data), W'(0));
        check("rst_kx", 32'(b_kx), 32'd0);
        check("rst_ly", 32'(b_ly), 32'd0);
        check("rst_done", 32'(b_done), 32'd0);
        check("rst_busy", 32'(b_busy), 32'd0);
        check("rst_overflow", 32'(b_ov), 32'd0);
        check("rst_line_err", 32'(b_lerr), 32'd0);
        check("rst_max", 32'(b_max), 32'd0);
        check("rst_state", 32'(b_state), 32'd0);
        reset = 1'b0;
        step();

        // Inputs other than frame_start are ignored while idle.
        set_in(1'b1, 8'hAA, 1'b0, 1'b1, 1'b1);
        step();
        set_in(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
        step();
        check("idle_ignore_state", 32'(b_state), 32'd0);

        // Full frame: 3 lines of 64 pixels, 6 words at 0..5.
        drive_line(64, 0, 1'b1, 1'b1, 1'b0);
        check("capture_busy", 32'(b_busy), 32'd1);
        check("capture_state", 32'(b_state), 32'd1);
        drive_line(64, 0, 1'b0, 1'b1, 1'b0);
        drive_line(64, 0, 1'b0, 1'b1, 1'b1);
        check_frame_end(2, 3, 0, 0, 63);
        check("done_count_1", 32'(done_cnt), 32'd1);

        // Partial kernel: 40-pixel lines with a stray empty line_end between.
        drive_line(40, 0, 1'b1, 1'b1, 1'b0);
        set_in(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
        step();
        set_in(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
        step();
        drive_line(40, 100, 1'b0, 1'b1, 1'b1);
        check_frame_end(2, 2, 0, 0, 139);

        // Line mismatch: 64 then 96 pixels.
        drive_line(64, 0, 1'b1, 1'b1, 1'b0);
        drive_line(96, 0, 1'b0, 1'b1, 1'b1);
        check_frame_end(2, 2, 1, 0, 95);
        check("done_count_3", 32'(done_cnt), 32'd3);

        // Overflow on the 4-word instance: 6 full words in one line.
        use_ov = 1'b1;
        drive_line(192, 0, 1'b1, 1'b1, 1'b1);
        check_frame_end(6, 1, 0, 1, 191);
        check("ov_write_count", 32'(ov_wr_cnt), 32'd4);
        check("ov_done_count", 32'(ov_done_cnt), 32'd1);
        use_ov = 1'b0;
        set_in(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
        step();

        // Abort: 10 words, then a new frame_start and a one-line frame.
        drive_line(320, 0, 1'b1, 1'b0, 1'b0);
        step();
        step();
        check("abort_no_done", 32'(done_cnt), 32'd3);
        drive_line(32, 7, 1'b1, 1'b1, 1'b1);
        check_frame_end(1, 1, 0, 0, 38);
        check("done_count_4", 32'(done_cnt), 32'd4);

        // Reset mid-line clears every output at the next edge.
        drive_line(20, 0, 1'b1, 1'b0, 1'b0);
        check("midline_busy", 32'(b_busy), 32'd1);
        set_in(1'b1, 8'h55, 1'b0, 1'b1, 1'b1);
        reset = 1'b1;
        step();
        check("mrst_mem_we", 32'(bif.mem_we), 32'd0);
        check("mrst_kx", 32'(b_kx), 32'd0);
        check("mrst_ly", 32'(b_ly), 32'd0);
        check("mrst_busy", 32'(b_busy), 32'd0);
        check("mrst_state", 32'(b_state), 32'd0);
        check("mrst_max", 32'(b_max), 32'd0);
        reset = 1'b0;
        set_in(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
        step();
        step();
        step();
        check("mrst_no_done", 32'(done_cnt), 32'd4);

        // Max pixel: one line peaking at 200.
        drive_line(32, 169, 1'b1, 1'b1, 1'b1);
        check_frame_end(1, 1, 0, 0, 200);
        check("done_count_5", 32'(done_cnt), 32'd5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
